// File: rtl/int24_to_float.sv
// Converts a signed 24-bit two's-complement sample into an exact IEEE-754 single,
// normalising the magnitude one bit per cycle before packing the result.
module int24_to_float (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [23:0] i_DATA,
    input  logic        i_DATA_VALID,
    output logic        o_DATA_READY,
    output logic [31:0] o_FLOAT,
    output logic        o_FLOAT_VALID,
    input  logic        i_FLOAT_ACK
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABS,
        ST_NORM,
        ST_PACK,
        ST_FINISH
    } state_t;

    state_t      stateQ, stateD;
    logic [23:0] dataQ, dataD;
    logic        signQ, signD;
    logic [23:0] magQ, magD;
    logic [7:0]  expQ, expD;
    logic        zeroQ, zeroD;
    logic [31:0] floatQ, floatD;
    logic        floatValidQ, floatValidD;
    logic        dataReadyQ, dataReadyD;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            stateQ      <= ST_IDLE;
            dataQ       <= 24'd0;
            signQ       <= 1'b0;
            magQ        <= 24'd0;
            expQ        <= 8'd0;
            zeroQ       <= 1'b0;
            floatQ      <= 32'd0;
            floatValidQ <= 1'b0;
            dataReadyQ  <= 1'b1;
        end else begin
            stateQ      <= stateD;
            dataQ       <= dataD;
            signQ       <= signD;
            magQ        <= magD;
            expQ        <= expD;
            zeroQ       <= zeroD;
            floatQ      <= floatD;
            floatValidQ <= floatValidD;
            dataReadyQ  <= dataReadyD;
        end
    end

    // The most negative input negates to 0x800000, which is still a correct unsigned magnitude.
    always_comb begin
        stateD      = stateQ;
        dataD       = dataQ;
        signD       = signQ;
        magD        = magQ;
        expD        = expQ;
        zeroD       = zeroQ;
        floatD      = floatQ;
        floatValidD = floatValidQ;
        dataReadyD  = dataReadyQ;

        case (stateQ)
            ST_IDLE: begin
                if (i_DATA_VALID && dataReadyQ) begin
                    dataD      = i_DATA;
                    dataReadyD = 1'b0;
                    stateD     = ST_ABS;
                end
            end
            ST_ABS: begin
                signD  = dataQ[23];
                magD   = dataQ[23] ? (~dataQ + 24'd1) : dataQ;
                expD   = 8'd150;
                zeroD  = (dataQ == 24'd0);
                stateD = (dataQ == 24'd0) ? ST_PACK : ST_NORM;
            end
            ST_NORM: begin
                if (magQ[23]) begin
                    stateD = ST_PACK;
                end else begin
                    magD = {magQ[22:0], 1'b0};
                    expD = expQ - 8'd1;
                end
            end
            ST_PACK: begin
                floatD      = zeroQ ? 32'h0000_0000 : {signQ, expQ, magQ[22:0]};
                floatValidD = 1'b1;
                stateD      = ST_FINISH;
            end
            ST_FINISH: begin
                if (floatValidQ && i_FLOAT_ACK) begin
                    floatValidD = 1'b0;
                    dataReadyD  = 1'b1;
                    stateD      = ST_IDLE;
                end
            end
            default: begin
                floatValidD = 1'b0;
                dataReadyD  = 1'b1;
                stateD      = ST_IDLE;
            end
        endcase
    end

    assign o_DATA_READY  = dataReadyQ;
    assign o_FLOAT       = floatQ;
    assign o_FLOAT_VALID = floatValidQ;

endmodule

// File: tb/tb_int24_to_float.sv
// Self-checking bench for int24_to_float: directed corner cases, backpressure,
// mid-conversion reset and random samples against a real-valued reference.
`timescale 1ns/1ps
module tb_int24_to_float;

    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b0;
    logic [23:0] i_DATA = 24'd0;
    logic        i_DATA_VALID = 1'b0;
    logic        o_DATA_READY;
    logic [31:0] o_FLOAT;
    logic        o_FLOAT_VALID;
    logic        i_FLOAT_ACK = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] sbFloat[$];
    int          sbLat[$];

    int24_to_float dut (
        .i_CLK         (i_CLK),
        .i_RST         (i_RST),
        .i_DATA        (i_DATA),
        .i_DATA_VALID  (i_DATA_VALID),
        .o_DATA_READY  (o_DATA_READY),
        .o_FLOAT       (o_FLOAT),
        .o_FLOAT_VALID (o_FLOAT_VALID),
        .i_FLOAT_ACK   (i_FLOAT_ACK)
    );

    always #5 i_CLK = ~i_CLK;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference built from the double-precision encoding of the integer value.
    function automatic logic [31:0] refFloat(input logic [23:0] v);
        int          iv;
        real         r;
        logic [63:0] b;
        int          e;
        logic [7:0]  e8;
        iv = $signed(v);
        if (iv == 0) return 32'h0000_0000;
        r  = iv;
        b  = $realtobits(r);
        e  = int'(b[62:52]) - 1023 + 127;
        e8 = e[7:0];
        return {b[63], e8, b[51:29]};
    endfunction

    function automatic int refLat(input logic [23:0] v);
        int          iv;
        real         r;
        logic [63:0] b;
        iv = $signed(v);
        if (iv == 0) return 2;
        r = iv;
        b = $realtobits(r);
        return 26 - (int'(b[62:52]) - 1023);
    endfunction

    task automatic applyStimulus(input logic [23:0] v, input logic [31:0] expF, input int expL,
                                 input int ackDelay, input bit backpressure);
        int          w;
        int          lat;
        logic [31:0] gotF;
        w = 0;
        while (!o_DATA_READY && w < 60) begin
            @(posedge i_CLK); #1;
            w++;
        end
        checkOutput("readyWait", {31'd0, o_DATA_READY}, 32'd1);
        i_DATA       = v;
        i_DATA_VALID = 1'b1;
        sbFloat.push_back(expF);
        sbLat.push_back(expL);
        @(posedge i_CLK); #1;
        i_DATA_VALID = 1'b0;
        lat = 0;
        while (!o_FLOAT_VALID && lat < 40) begin
            @(posedge i_CLK); #1;
            lat++;
        end
        checkOutput("validSeen", {31'd0, o_FLOAT_VALID}, 32'd1);
        checkOutput("float", o_FLOAT, sbFloat.pop_front());
        checkOutput("latency", lat, sbLat.pop_front());
        gotF = o_FLOAT;
        for (int i = 0; i < ackDelay; i++) begin
            if (backpressure) begin
                i_DATA       = 24'h123456;
                i_DATA_VALID = 1'b1;
            end
            @(posedge i_CLK); #1;
            if (backpressure) begin
                checkOutput("bpValid", {31'd0, o_FLOAT_VALID}, 32'd1);
                checkOutput("bpReady", {31'd0, o_DATA_READY}, 32'd0);
                checkOutput("bpFloat", o_FLOAT, expF);
            end
        end
        i_FLOAT_ACK = 1'b1;
        @(posedge i_CLK); #1;
        i_FLOAT_ACK  = 1'b0;
        i_DATA_VALID = 1'b0;
        checkOutput("ackValidLow", {31'd0, o_FLOAT_VALID}, 32'd0);
        checkOutput("ackReadyHigh", {31'd0, o_DATA_READY}, 32'd1);
        checkOutput("floatHeld", o_FLOAT, gotF);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [23:0] v;
        bit          sawValid;

        $display("[TB] starting int24_to_float bench");
        #1 i_RST = 1'b1;
        #1;
        checkOutput("rstReady", {31'd0, o_DATA_READY}, 32'd1);
        checkOutput("rstValid", {31'd0, o_FLOAT_VALID}, 32'd0);
        checkOutput("rstFloat", o_FLOAT, 32'd0);
        @(posedge i_CLK); @(negedge i_CLK);
        i_RST = 1'b0;

        applyStimulus(24'h000001, 32'h3F80_0000, 26, 0, 1'b0);
        applyStimulus(24'h000000, 32'h0000_0000, 2, 1, 1'b0);
        applyStimulus(24'hFFFFFF, 32'hBF80_0000, 26, 0, 1'b0);
        applyStimulus(24'h7FFFFF, 32'h4AFF_FFFE, 4, 2, 1'b0);
        applyStimulus(24'h800000, 32'hCB00_0000, 3, 0, 1'b0);
        applyStimulus(24'd250,    32'h437A_0000, 19, 0, 1'b0);
        applyStimulus(24'hFFFF06, 32'hC37A_0000, 19, 20, 1'b1);

        // Reset in the middle of normalising: outputs clear without a clock, no result follows.
        i_DATA       = 24'h000001;
        i_DATA_VALID = 1'b1;
        @(posedge i_CLK); #1;
        i_DATA_VALID = 1'b0;
        sbFloat.push_back(32'h3F80_0000);
        sbLat.push_back(26);
        repeat (5) @(posedge i_CLK);
        #2 i_RST = 1'b1;
        #1;
        sbFloat.delete();
        sbLat.delete();
        checkOutput("midRstValid", {31'd0, o_FLOAT_VALID}, 32'd0);
        checkOutput("midRstReady", {31'd0, o_DATA_READY}, 32'd1);
        checkOutput("midRstFloat", o_FLOAT, 32'd0);
        @(negedge i_CLK);
        i_RST = 1'b0;
        sawValid = 1'b0;
        repeat (30) begin
            @(posedge i_CLK); #1;
            if (o_FLOAT_VALID) sawValid = 1'b1;
        end
        checkOutput("noPulseAfterRst", {31'd0, sawValid}, 32'd0);
        applyStimulus(24'h000002, 32'h4000_0000, 25, 0, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            rnd = $urandom;
            v   = rnd[23:0];
            applyStimulus(v, refFloat(v), refLat(v), $urandom_range(0, 4), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
